// File: rtl/dlx_data_mem_if.sv
// rtl/dlx_data_mem_if.sv - DLX data-port bus between the core and the data RAM
//
// Signals:
//   d_address      byte address from the core (bits [1:0] ignored by the RAM)
//   d_data_write   write data
//   d_write_enable write strobe, committed at the next rising edge
//   d_data_read    read data for the tracked address
//   d_data_valid   d_data_read matches the current d_address
//
// Modports: master = core side, slave = RAM side.
interface dlx_data_mem_if;
    logic [31:0] d_address;
    logic [31:0] d_data_write;
    logic        d_write_enable;
    logic [31:0] d_data_read;
    logic        d_data_valid;

    modport master (
        output d_address,
        output d_data_write,
        output d_write_enable,
        input  d_data_read,
        input  d_data_valid
    );

    modport slave (
        input  d_address,
        input  d_data_write,
        input  d_write_enable,
        output d_data_read,
        output d_data_valid
    );
endinterface

// File: rtl/dlx_data_mem.sv
// rtl/dlx_data_mem.sv - word-addressed data RAM with programmable read latency
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset (memory contents are kept)
//   bus    dlx_data_mem_if.slave: d_address / d_data_write / d_write_enable in,
//          d_data_read / d_data_valid out
//
// Parameters:
//   ADDR_W   word-index width, DEPTH = 2**ADDR_W words of 32 bits
//   LATENCY  cycles from a new, held address to d_data_valid (1..15)
module dlx_data_mem #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    dlx_data_mem_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } state_t;

    logic [31:0]       mem [DEPTH];

    state_t            state;
    state_t            next_state;
    logic [29:0]       cur_addr;
    logic [3:0]        cnt;
    logic [3:0]        next_cnt;
    logic              load;
    logic [31:0]       data_read;

    logic [29:0]       word_addr;
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              hit;
    logic              wr_hit;
    logic              wr_commit;
    logic              restart;
    logic [31:0]       load_value;

    // Byte-offset bits are intentionally ignored.
    logic              unused_byte_bits;
    assign unused_byte_bits = &{1'b0, bus.d_address[1:0]};

    assign word_addr = bus.d_address[31:2];
    assign idx       = bus.d_address[ADDR_W+1:2];
    assign in_range  = (bus.d_address[31:ADDR_W+2] == '0);
    assign hit       = (word_addr == cur_addr);
    assign wr_hit    = bus.d_write_enable && hit;
    assign wr_commit = bus.d_write_enable && in_range;

    // Any write to the tracked word invalidates the data already loaded,
    // so it restarts the latency count just like an address change.
    assign restart   = (state == IDLE) || !hit || wr_hit;

    // Forward a same-edge write so the loaded word is never stale.
    always_comb begin
        load_value = 32'h0000_0000;
        if (wr_commit) begin
            load_value = bus.d_data_write;
        end else if (in_range) begin
            load_value = mem[idx];
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        load       = 1'b0;
        if (restart) begin
            if (LATENCY == 1) begin
                load       = 1'b1;
                next_state = READY;
            end else begin
                next_cnt   = 4'(LATENCY - 1);
                next_state = WAIT;
            end
        end else if (state == WAIT) begin
            if (cnt == 4'd1) begin
                load       = 1'b1;
                next_state = READY;
            end else begin
                next_cnt   = cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            cnt       <= '0;
            data_read <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (restart) begin
                cur_addr <= word_addr;
            end
            if (load) begin
                data_read <= load_value;
            end
        end
    end

    // Storage has no reset; writes are simply suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && wr_commit) begin
            mem[idx] <= bus.d_data_write;
        end
    end

    assign bus.d_data_read  = data_read;
    assign bus.d_data_valid = (state == READY) && hit && !wr_hit;

endmodule
